// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: register map, STATUS bit layout and FSM state type for pwm_capture.
// Ports: none (package).
package pwm_capture_pkg;

    localparam logic [1:0] ADDR_PERIOD = 2'd0;
    localparam logic [1:0] ADDR_HIGH   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int unsigned STAT_VALID     = 0;
    localparam int unsigned STAT_TIMEOUT   = 1;
    localparam int unsigned STAT_LEVEL     = 2;
    localparam int unsigned STAT_ENABLE    = 3;
    localparam int unsigned STAT_COUNT_LSB = 16;
    localparam int unsigned COUNT_W        = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    // Assemble the STATUS word; unlisted bits read as zero.
    function automatic logic [31:0] status_word(
        input logic               valid,
        input logic               timeout,
        input logic               level,
        input logic               enable,
        input logic [COUNT_W-1:0] count
    );
        logic [31:0] w;
        w                                       = '0;
        w[STAT_VALID]                           = valid;
        w[STAT_TIMEOUT]                         = timeout;
        w[STAT_LEVEL]                           = level;
        w[STAT_ENABLE]                          = enable;
        w[STAT_COUNT_LSB +: COUNT_W]            = count;
        return w;
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: two-flop synchronizer for the asynchronous PWM input plus
// a one-cycle delayed copy for rising-edge detection.
// Ports: clk, rst (sync, active-high), pwm_in (async) -> pwm_s (synchronized
// level), rise (one-cycle pulse on the first synchronized high cycle).
module pwm_edge_sync
    import pwm_capture_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic pwm_s,
    output logic rise
);

    logic meta;
    logic prev;

    // Synchronizer chain and edge-detect history.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b0;
            pwm_s <= 1'b0;
            prev  <= 1'b0;
        end else begin
            meta  <= pwm_in;
            pwm_s <= meta;
            prev  <= pwm_s;
        end
    end

    assign rise = pwm_s & ~prev;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: Avalon-MM slave measuring period and high time of a PWM input
// in clock cycles, with timeout on a stuck input.
// Ports: clk, rst (sync, active-high); Avalon slave avs_address[1:0],
// avs_read, avs_write, avs_writedata[31:0], avs_readdata[31:0] (latency 1);
// pwm_in (asynchronous PWM input).
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 50_000_000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    input  logic        pwm_in
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic               pwm_s;
    logic               rise;
    state_t             state;
    logic               enable;
    logic               valid;
    logic               timeout;
    logic [CNT_W-1:0]   period_cnt;
    logic [CNT_W-1:0]   high_cnt;
    logic [CNT_W-1:0]   period_reg;
    logic [CNT_W-1:0]   high_reg;
    logic [CNT_W-1:0]   high_shadow;
    logic [COUNT_W-1:0] capture_count;
    logic               ctrl_wr;
    logic               unused_wdata;

    pwm_edge_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .pwm_s  (pwm_s),
        .rise   (rise)
    );

    assign ctrl_wr      = avs_write && (avs_address == ADDR_CTRL);
    assign unused_wdata = ^avs_writedata[31:1];

    // Measurement FSM, counters, register file and registered read mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            enable        <= 1'b0;
            valid         <= 1'b0;
            timeout       <= 1'b0;
            period_cnt    <= '0;
            high_cnt      <= '0;
            period_reg    <= '0;
            high_reg      <= '0;
            high_shadow   <= '0;
            capture_count <= '0;
            avs_readdata  <= '0;
        end else begin
            // A disable write overrides any same-cycle rise or timeout.
            if (ctrl_wr && !avs_writedata[0]) begin
                state      <= IDLE;
                enable     <= 1'b0;
                valid      <= 1'b0;
                timeout    <= 1'b0;
                period_cnt <= '0;
                high_cnt   <= '0;
            end else if (ctrl_wr && avs_writedata[0] && state == IDLE) begin
                state      <= ARM;
                enable     <= 1'b1;
                period_cnt <= '0;
                high_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        period_cnt <= '0;
                        high_cnt   <= '0;
                    end
                    ARM: begin
                        // First edge only starts the measurement window.
                        if (rise) begin
                            state      <= MEASURE;
                            period_cnt <= CNT_ONE;
                            high_cnt   <= CNT_ONE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period_reg    <= period_cnt;
                            high_reg      <= high_cnt;
                            valid         <= 1'b1;
                            timeout       <= 1'b0;
                            capture_count <= capture_count + COUNT_W'(1);
                            period_cnt    <= CNT_ONE;
                            high_cnt      <= CNT_ONE;
                        end else if (period_cnt == TIMEOUT_CNT) begin
                            timeout    <= 1'b1;
                            valid      <= 1'b0;
                            state      <= ARM;
                            period_cnt <= '0;
                            high_cnt   <= '0;
                        end else begin
                            if (period_cnt != '1) begin
                                period_cnt <= period_cnt + CNT_ONE;
                            end
                            if (pwm_s && high_cnt != '1) begin
                                high_cnt <= high_cnt + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end

            // PERIOD read snapshots the pre-update HIGH so the pair stays coherent.
            if (avs_read) begin
                case (avs_address)
                    ADDR_PERIOD: begin
                        avs_readdata <= 32'(period_reg);
                        high_shadow  <= high_reg;
                    end
                    ADDR_HIGH:   avs_readdata <= 32'(high_shadow);
                    ADDR_STATUS: avs_readdata <= status_word(valid, timeout, pwm_s,
                                                             enable, capture_count);
                    ADDR_CTRL:   avs_readdata <= {31'd0, enable};
                endcase
            end
        end
    end

endmodule
